mux_sel_arbiter: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 21 ++
 rtl/mux_arb_timer.sv | 27 ++
 rtl/mux_sel_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mux_sel_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and reset constants for the two-requester mux select arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGuard,
        StGrant0,
        StGrant1
    } mux_arb_state_t;

    typedef logic mux_arb_owner_t;

    localparam logic           SelRst       = 1'b0;
    // Requester 0 wins the first contested arbitration after reset.
    localparam mux_arb_owner_t LastOwnerRst = 1'b1;

    function automatic mux_arb_state_t grant_state(input mux_arb_owner_t owner);
        return owner ? StGrant1 : StGrant0;
    endfunction

endpackage

// File: rtl/mux_arb_timer.sv
// Loadable down-counter with zero flag; times the settle interval after a sel change.
module mux_arb_timer #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the mux16to8 sel input with bounded hold and a settle guard.
// Optional grant/preempt statistics are built when MUX_ARB_STATS_EN is defined.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter int MAX_HOLD     = 8
`ifdef MUX_ARB_STATS_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             bus_valid
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [CNT_W-1:0] preempt_cnt
`endif
);

    localparam int HoldW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [HoldW-1:0]  HoldMax   = HoldW'(MAX_HOLD - 1);
    // The timer is loaded on the sel change, so it counts the guard cycles after the first one.
    localparam logic [GuardW-1:0] GuardLoad = GuardW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam bit                GuardEn   = (GUARD_CYCLES > 0);

    mux_arb_state_t   state_q, state_d;
    logic             sel_q, sel_d;
    logic             gnt0_q, gnt1_q;
    mux_arb_owner_t   last_owner_q, last_owner_d;
    mux_arb_owner_t   target, owner;
    logic [HoldW-1:0] hold_q, hold_d;
    logic             guard_load, guard_dec, guard_zero;
    logic             own_req, other_req, at_max;

    assign owner     = (state_q == StGrant1);
    assign own_req   = owner ? req1 : req0;
    assign other_req = owner ? req0 : req1;
    assign at_max    = (hold_q == HoldMax);

    mux_arb_timer #(
        .Width(GuardW)
    ) u_guard_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (guard_load),
        .load_val_i(GuardLoad),
        .dec_i     (guard_dec),
        .zero_o    (guard_zero)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        hold_d       = hold_q;
        last_owner_d = last_owner_q;
        guard_load   = 1'b0;
        guard_dec    = 1'b0;
        target       = sel_q;
        unique case (state_q)
            StIdle: begin
                target = (req0 && req1) ? ~last_owner_q : req1;
                if (req0 || req1) begin
                    if (target == sel_q) begin
                        state_d = grant_state(target);
                    end else begin
                        sel_d = target;
                        if (GuardEn) begin
                            guard_load = 1'b1;
                            state_d    = StGuard;
                        end else begin
                            state_d = grant_state(target);
                        end
                    end
                end
            end
            StGuard: begin
                guard_dec = 1'b1;
                if (guard_zero) begin
                    state_d = (sel_q ? req1 : req0) ? grant_state(sel_q) : StIdle;
                end
            end
            StGrant0, StGrant1: begin
                if (!own_req || (other_req && at_max)) begin
                    if (other_req) begin
                        sel_d = ~owner;
                        if (GuardEn) begin
                            guard_load = 1'b1;
                            state_d    = StGuard;
                        end else begin
                            state_d = grant_state(~owner);
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!at_max) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Every new grant, including a zero-guard owner swap, starts its hold count afresh.
        if (state_d != state_q) begin
            hold_d = '0;
        end
        if (state_d == StGrant0) begin
            last_owner_d = 1'b0;
        end else if (state_d == StGrant1) begin
            last_owner_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= SelRst;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            last_owner_q <= LastOwnerRst;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            gnt0_q       <= (state_d == StGrant0);
            gnt1_q       <= (state_d == StGrant1);
            last_owner_q <= last_owner_d;
            hold_q       <= hold_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sel       = sel_q;
    assign bus_valid = gnt0_q | gnt1_q;

`ifdef MUX_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt1_q, preempt_cnt_q;
    logic             enter0, enter1, preempt;

    assign enter0  = (state_d == StGrant0) && (state_q != StGrant0);
    assign enter1  = (state_d == StGrant1) && (state_q != StGrant1);
    assign preempt = ((state_q == StGrant0) || (state_q == StGrant1)) &&
                     own_req && other_req && at_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_q  <= '0;
            grant_cnt1_q  <= '0;
            preempt_cnt_q <= '0;
        end else begin
            if (enter0 && (grant_cnt0_q != CntMax)) grant_cnt0_q <= grant_cnt0_q + 1'b1;
            if (enter1 && (grant_cnt1_q != CntMax)) grant_cnt1_q <= grant_cnt1_q + 1'b1;
            if (preempt && (preempt_cnt_q != CntMax)) preempt_cnt_q <= preempt_cnt_q + 1'b1;
        end
    end

    assign grant_cnt0  = grant_cnt0_q;
    assign grant_cnt1  = grant_cnt1_q;
    assign preempt_cnt = preempt_cnt_q;
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: ownership model plus directed literal checks.
// Stats outputs are checked when MUX_ARB_STATS_EN is defined.
module tb_mux_sel_arbiter;

    localparam int G = 2;
    localparam int H = 4;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic gnt0, gnt1, sel, bus_valid;
`ifdef MUX_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, preempt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model: who owns the bus, how many guard cycles remain, how long the owner has held it.
    int m_owner = 2;  // 2 = nobody
    int m_dead  = 0;
    int m_held  = 0;
    int m_sel   = 0;
    int m_last  = 1;
    int m_g0    = 0;
    int m_g1    = 0;
    int m_pre   = 0;
    bit m_on    = 1'b0;

    mux_sel_arbiter #(
        .GUARD_CYCLES(G),
        .MAX_HOLD    (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .sel        (sel),
        .bus_valid  (bus_valid)
`ifdef MUX_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .preempt_cnt(preempt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_grant(input int t);
        m_owner = t;
        m_held  = 1;
        m_last  = t;
        if (t == 0) m_g0++;
        else m_g1++;
    endtask

    task automatic m_switch(input int t);
        m_sel   = t;
        m_owner = 2;
        if (G > 0) m_dead = G;
        else m_grant(t);
    endtask

    task automatic m_step(input bit r0, input bit r1);
        bit rq [2];
        bit mine, other;
        int t;
        rq[0] = r0;
        rq[1] = r1;
        if (m_owner != 2) begin
            mine  = rq[m_owner];
            other = rq[1 - m_owner];
            if (!mine || (other && m_held >= H)) begin
                if (mine) m_pre++;
                if (other) m_switch(1 - m_owner);
                else m_owner = 2;
            end else begin
                m_held++;
            end
        end else if (m_dead > 0) begin
            m_dead--;
            if (m_dead == 0 && rq[m_sel]) m_grant(m_sel);
        end else if (r0 || r1) begin
            t = (r0 && r1) ? 1 - m_last : (r1 ? 1 : 0);
            if (t == m_sel) m_grant(t);
            else m_switch(t);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = 2; m_dead = 0; m_held = 0; m_sel = 0; m_last = 1;
                m_g0 = 0; m_g1 = 0; m_pre = 0; m_on = 1'b1;
            end else if (m_on) begin
                m_step(req0, req1);
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model_gnt0", gnt0, m_owner == 0);
            chk("model_gnt1", gnt1, m_owner == 1);
            chk("model_sel", sel, m_sel);
            chk("model_bus_valid", bus_valid, m_owner != 2);
`ifdef MUX_ARB_STATS_EN
            chk("model_grant_cnt0", grant_cnt0, m_g0);
            chk("model_grant_cnt1", grant_cnt1, m_g1);
            chk("model_preempt_cnt", preempt_cnt, m_pre);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect3(input string name, input bit g0, input bit g1, input bit s);
        chk({name, "_gnt0"}, gnt0, g0);
        chk({name, "_gnt1"}, gnt1, g1);
        chk({name, "_sel"}, sel, s);
        chk({name, "_bus_valid"}, bus_valid, g0 | g1);
    endtask

    // {gnt0, gnt1, sel} per cycle with both requesting from reset.
    logic [2:0] rr_exp [13] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001,
                                3'b011, 3'b011, 3'b011, 3'b011, 3'b000, 3'b000, 3'b100};

    initial begin
        step(); step();
        expect3("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); step();

        // Same-sel grant after one edge.
        req0 = 1'b1;
        step();
        expect3("same_sel", 1'b1, 1'b0, 1'b0);
        chk("pin_model_owner0", m_owner, 0);
        step();
        expect3("same_sel_hold", 1'b1, 1'b0, 1'b0);
        req0 = 1'b0;
        step();
        expect3("release0", 1'b0, 1'b0, 1'b0);

        // Cross-sel grant: sel moves, two dead cycles, then grant.
        req1 = 1'b1;
        step();
        expect3("cross_guard1", 1'b0, 1'b0, 1'b1);
        step();
        expect3("cross_guard2", 1'b0, 1'b0, 1'b1);
        step();
        expect3("cross_grant", 1'b0, 1'b1, 1'b1);
        req1 = 1'b0;
        step();
        expect3("release1", 1'b0, 1'b0, 1'b1);

        // Contested round-robin from reset.
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        step();
        expect3("rr_reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step();
            expect3($sformatf("rr%0d", i), rr_exp[i][2], rr_exp[i][1], rr_exp[i][0]);
        end
        chk("pin_model_preempts", m_pre, 2);
`ifdef MUX_ARB_STATS_EN
        chk("stats_grant_cnt0", grant_cnt0, 2);
        chk("stats_grant_cnt1", grant_cnt1, 1);
        chk("stats_preempt_cnt", preempt_cnt, 2);
`endif
        req0 = 1'b0; req1 = 1'b0;
        step();
        expect3("rr_release", 1'b0, 1'b0, 1'b0);

        // Requester drops during guard: no grant, sel stays.
        req1 = 1'b1;
        step();
        expect3("drop_guard1", 1'b0, 1'b0, 1'b1);
        req1 = 1'b0;
        step(); step();
        expect3("drop_after", 1'b0, 1'b0, 1'b1);
        step();
        expect3("drop_idle", 1'b0, 1'b0, 1'b1);

        // Reset during GRANT1, then a fast req0 grant.
        req1 = 1'b1;
        step();
        expect3("pre_rst_grant1", 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        expect3("rst_in_grant", 1'b0, 1'b0, 1'b0);
        rst = 1'b0; req1 = 1'b0; req0 = 1'b1;
        step();
        expect3("post_rst_grant0", 1'b1, 1'b0, 1'b0);

        // Release of req0 and assert of req1 together: straight to guard.
        req0 = 1'b0; req1 = 1'b1;
        step();
        expect3("handover_guard", 1'b0, 1'b0, 1'b1);
        step(); step();
        expect3("handover_grant", 1'b0, 1'b1, 1'b1);

        // Long uncontested grant saturates, then yields one edge after req0 appears.
        for (int i = 0; i < 8; i++) step();
        expect3("uncontested", 1'b0, 1'b1, 1'b1);
        req0 = 1'b1;
        step();
        expect3("sat_preempt", 1'b0, 1'b0, 1'b0);
        step(); step();
        expect3("sat_regrant0", 1'b1, 1'b0, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
